// File: rtl/guess_round_ctrl.sv
// guess_round_ctrl
//   Two-player number-guessing round controller. A round starts by latching a
//   secret target. Each player may then submit up to MAX_TRIES guesses through
//   a valid/ready handshake. At most one guess is accepted per cycle, and a
//   round-robin pointer breaks ties between the players. Every accepted guess
//   produces a one-cycle hint on the following cycle. An equal guess ends the
//   round with that player as the winner. If neither player guesses the target
//   before both run out of guesses, the round ends with no winner.
//
// Ports
//   clk                  system clock, rising edge
//   reset                synchronous active-high reset
//   start                begin a new round (honoured in IDLE and DONE)
//   target_num[7:0]      secret number, latched on an honoured start
//   p0_valid, p0_guess   player 0 guess handshake (input side)
//   p1_valid, p1_guess   player 1 guess handshake (input side)
//   p0_ready, p1_ready   guess accepted this cycle when valid & ready
//   hint_valid           one-cycle pulse carrying hint_player / hint
//   hint_player          player the hint belongs to
//   hint[1:0]            00 equal, 01 guess too low, 10 guess too high
//   result[1:0]          00 none, 01 p0 won, 10 p1 won, 11 no winner
//   done                 high while the round is over
//   tries0, tries1       guesses consumed by each player this round
module guess_round_ctrl #(
    parameter int MAX_TRIES = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] target_num,
    input  logic       p0_valid,
    input  logic [7:0] p0_guess,
    input  logic       p1_valid,
    input  logic [7:0] p1_guess,
    output logic       p0_ready,
    output logic       p1_ready,
    output logic       hint_valid,
    output logic       hint_player,
    output logic [1:0] hint,
    output logic [1:0] result,
    output logic       done,
    output logic [2:0] tries0,
    output logic [2:0] tries1
);

    localparam logic [2:0] MAX_T = 3'(MAX_TRIES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_DONE
    } state_t;

    state_t     state_reg;
    logic [7:0] target_reg;
    logic [2:0] tries0_reg;
    logic [2:0] tries1_reg;
    logic [1:0] result_reg;
    logic       ptr_reg;          // 0: player 0 wins a tie, 1: player 1 wins
    logic       hint_valid_reg;
    logic       hint_player_reg;
    logic [1:0] hint_reg;
    logic       done_reg;

    logic       elig0;
    logic       elig1;
    logic       grant0;
    logic       grant1;
    logic       grant_any;
    logic [7:0] guess_sel;
    logic [1:0] hint_next;
    logic [2:0] tries0_next;
    logic [2:0] tries1_next;

    // Exhausted players are never eligible, so their ready stays low.
    assign elig0 = (state_reg == S_PLAY) && p0_valid && (tries0_reg < MAX_T);
    assign elig1 = (state_reg == S_PLAY) && p1_valid && (tries1_reg < MAX_T);

    // The pointer only matters when both players contend.
    assign grant0    = elig0 && (!elig1 || !ptr_reg);
    assign grant1    = elig1 && (!elig0 ||  ptr_reg);
    assign grant_any = grant0 || grant1;

    assign guess_sel = grant1 ? p1_guess : p0_guess;

    always_comb begin
        hint_next = 2'b00;
        if (guess_sel < target_reg) begin
            hint_next = 2'b01;
        end else if (guess_sel > target_reg) begin
            hint_next = 2'b10;
        end
    end

    assign tries0_next = tries0_reg + 3'(grant0);
    assign tries1_next = tries1_reg + 3'(grant1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= S_IDLE;
            target_reg      <= 8'd0;
            tries0_reg      <= 3'd0;
            tries1_reg      <= 3'd0;
            result_reg      <= 2'b00;
            ptr_reg         <= 1'b0;
            hint_valid_reg  <= 1'b0;
            hint_player_reg <= 1'b0;
            hint_reg        <= 2'b00;
            done_reg        <= 1'b0;
        end else begin
            hint_valid_reg <= 1'b0;
            if ((state_reg == S_IDLE || state_reg == S_DONE) && start) begin
                state_reg  <= S_PLAY;
                target_reg <= target_num;
                tries0_reg <= 3'd0;
                tries1_reg <= 3'd0;
                result_reg <= 2'b00;
                ptr_reg    <= 1'b0;
                done_reg   <= 1'b0;
            end else if (state_reg == S_PLAY && grant_any) begin
                tries0_reg      <= tries0_next;
                tries1_reg      <= tries1_next;
                ptr_reg         <= grant0;   // favour the player just skipped
                hint_valid_reg  <= 1'b1;
                hint_player_reg <= grant1;
                hint_reg        <= hint_next;
                if (hint_next == 2'b00) begin
                    result_reg <= grant1 ? 2'b10 : 2'b01;
                    state_reg  <= S_DONE;
                    done_reg   <= 1'b1;
                end else if (tries0_next == MAX_T && tries1_next == MAX_T) begin
                    result_reg <= 2'b11;
                    state_reg  <= S_DONE;
                    done_reg   <= 1'b1;
                end
            end
        end
    end

    assign p0_ready    = grant0;
    assign p1_ready    = grant1;
    assign hint_valid  = hint_valid_reg;
    assign hint_player = hint_player_reg;
    assign hint        = hint_reg;
    assign result      = result_reg;
    assign done        = done_reg;
    assign tries0      = tries0_reg;
    assign tries1      = tries1_reg;

endmodule

// File: tb/tb_guess_round_ctrl.sv
// tb_guess_round_ctrl
//   Directed bench for guess_round_ctrl. The primary instance uses the default
//   MAX_TRIES. A second instance with MAX_TRIES=2 shares the same inputs and
//   is checked only in the exhaustion scenario.
module tb_guess_round_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] target_num;
    logic       p0_valid;
    logic [7:0] p0_guess;
    logic       p1_valid;
    logic [7:0] p1_guess;

    logic       p0_ready, p1_ready, out_hint_valid, out_hint_player, done;
    logic [1:0] out_hint, result;
    logic [2:0] tries0, tries1;

    logic       p0_ready_m2, p1_ready_m2, out_hint_valid_m2, out_hint_player_m2, done_m2;
    logic [1:0] out_hint_m2, result_m2;
    logic [2:0] tries0_m2, tries1_m2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    guess_round_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .target_num(target_num),
        .p0_valid(p0_valid), .p0_guess(p0_guess),
        .p1_valid(p1_valid), .p1_guess(p1_guess),
        .p0_ready(p0_ready), .p1_ready(p1_ready),
        .hint_valid(out_hint_valid), .hint_player(out_hint_player), .hint(out_hint),
        .result(result), .done(done), .tries0(tries0), .tries1(tries1)
    );

    guess_round_ctrl #(.MAX_TRIES(2)) dut_m2 (
        .clk(clk), .reset(reset), .start(start), .target_num(target_num),
        .p0_valid(p0_valid), .p0_guess(p0_guess),
        .p1_valid(p1_valid), .p1_guess(p1_guess),
        .p0_ready(p0_ready_m2), .p1_ready(p1_ready_m2),
        .hint_valid(out_hint_valid_m2), .hint_player(out_hint_player_m2), .hint(out_hint_m2),
        .result(result_m2), .done(done_m2), .tries0(tries0_m2), .tries1(tries1_m2)
    );

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // Returns 1 ns after the next rising edge; inputs are then driven there.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; target_num = 8'd0;
        p0_valid = 1'b0; p0_guess = 8'd0; p1_valid = 1'b0; p1_guess = 8'd0;
        tick();
        tick();

        // Reset state; readys must stay low even with valids high.
        p0_valid = 1'b1; p1_valid = 1'b1;
        #1;
        check_val("rst_done", done, 0);
        check_val("rst_result", result, 0);
        check_val("rst_tries0", tries0, 0);
        check_val("rst_tries1", tries1, 0);
        check_val("rst_hint_valid", out_hint_valid, 0);
        check_val("rst_hint", out_hint, 0);
        check_val("rst_hint_player", out_hint_player, 0);
        check_val("rst_p0_ready", p0_ready, 0);
        check_val("rst_p1_ready", p1_ready, 0);
        reset = 1'b0; p0_valid = 1'b0; p1_valid = 1'b0;
        tick();

        // Round A, target 9: single p0 guess, single p1 guess, then contention.
        target_num = 8'd9; start = 1'b1;
        tick();
        start = 1'b0;
        p0_valid = 1'b1; p0_guess = 8'd3;
        #1;
        check_val("a_p0_ready", p0_ready, 1);
        check_val("a_p1_ready", p1_ready, 0);
        tick();
        p0_valid = 1'b0;
        check_val("a_hint_valid", out_hint_valid, 1);
        check_val("a_hint_player", out_hint_player, 0);
        check_val("a_hint", out_hint, 2'b01);
        check_val("a_tries0", tries0, 1);
        p1_valid = 1'b1; p1_guess = 8'd20;
        #1;
        check_val("a_p1_ready", p1_ready, 1);
        tick();
        p1_valid = 1'b0;
        check_val("a_hint_p1", out_hint, 2'b10);
        check_val("a_hint_player_p1", out_hint_player, 1);
        check_val("a_tries1", tries1, 1);

        // Both valid; pointer is back at player 0.
        p0_valid = 1'b1; p1_valid = 1'b1; p0_guess = 8'd3; p1_guess = 8'd9;
        #1;
        check_val("a_both_p0_ready", p0_ready, 1);
        check_val("a_both_p1_ready", p1_ready, 0);
        tick();
        check_val("a_both_hint0", out_hint, 2'b01);
        #1;
        check_val("a_rr_p0_ready", p0_ready, 0);
        check_val("a_rr_p1_ready", p1_ready, 1);
        tick();
        check_val("a_win_hint_valid", out_hint_valid, 1);
        check_val("a_win_hint_player", out_hint_player, 1);
        check_val("a_win_hint", out_hint, 2'b00);
        check_val("a_win_result", result, 2'b10);
        check_val("a_win_done", done, 1);
        check_val("a_win_tries0", tries0, 2);
        check_val("a_win_tries1", tries1, 2);
        #1;
        check_val("a_done_p0_ready", p0_ready, 0);
        check_val("a_done_p1_ready", p1_ready, 0);
        p0_valid = 1'b0; p1_valid = 1'b0;
        tick();
        check_val("a_done_hint_pulse", out_hint_valid, 0);
        check_val("a_done_result_hold", result, 2'b10);

        // Round B, target 3: p0 wins.
        target_num = 8'd3; start = 1'b1;
        tick();
        start = 1'b0;
        check_val("b_tries0_clr", tries0, 0);
        check_val("b_tries1_clr", tries1, 0);
        check_val("b_result_clr", result, 0);
        check_val("b_done_clr", done, 0);
        p0_valid = 1'b1; p0_guess = 8'd3;
        tick();
        p0_valid = 1'b0;
        check_val("b_result", result, 2'b01);
        check_val("b_done", done, 1);

        // Round C, from DONE with result 01, target 3: p1 wins.
        target_num = 8'd3; start = 1'b1;
        tick();
        start = 1'b0;
        check_val("c_result_clr", result, 0);
        p1_valid = 1'b1; p1_guess = 8'd3;
        #1;
        check_val("c_p1_ready", p1_ready, 1);
        tick();
        p1_valid = 1'b0;
        check_val("c_result", result, 2'b10);
        check_val("c_hint_player", out_hint_player, 1);

        // Round D, target 100: continuous contention alternates 0,1,0,1.
        target_num = 8'd100; start = 1'b1;
        tick();
        start = 1'b0;
        p0_valid = 1'b1; p1_valid = 1'b1; p0_guess = 8'd50; p1_guess = 8'd200;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_val($sformatf("d_p0_ready_%0d", i), p0_ready, (i % 2 == 0) ? 1 : 0);
            check_val($sformatf("d_p1_ready_%0d", i), p1_ready, (i % 2 == 1) ? 1 : 0);
            tick();
            check_val($sformatf("d_hint_player_%0d", i), out_hint_player, (i % 2 == 1) ? 1 : 0);
            check_val($sformatf("d_hint_%0d", i), out_hint, (i % 2 == 1) ? 2 : 1);
        end
        check_val("d_tries0", tries0, 2);
        check_val("d_tries1", tries1, 2);
        p0_valid = 1'b0; p1_valid = 1'b0;
        tick();
        check_val("d_idle_hint_valid", out_hint_valid, 0);
        // start and target changes mid-round are ignored.
        target_num = 8'd50; start = 1'b1;
        tick();
        start = 1'b0;
        check_val("d_start_ignored_tries0", tries0, 2);
        p0_valid = 1'b1; p1_valid = 1'b1; p0_guess = 8'd50;
        #1;
        check_val("d_ptr_kept_p0_ready", p0_ready, 1);
        p1_valid = 1'b0;
        tick();
        check_val("d_old_target_hint", out_hint, 2'b01);
        check_val("d_old_target_done", done, 0);
        check_val("d_tries0_3", tries0, 3);

        // Reset mid-round with a transfer pending: reset wins.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("r_tries0", tries0, 0);
        check_val("r_tries1", tries1, 0);
        check_val("r_hint_valid", out_hint_valid, 0);
        check_val("r_hint", out_hint, 0);
        check_val("r_result", result, 0);
        check_val("r_done", done, 0);
        #1;
        check_val("r_p0_ready", p0_ready, 0);

        // Round E, target 6, all guesses 15 on both instances.
        p0_valid = 1'b0;
        target_num = 8'd6; start = 1'b1;
        tick();
        start = 1'b0;
        p0_valid = 1'b1; p1_valid = 1'b1; p0_guess = 8'd15; p1_guess = 8'd15;
        #1;
        check_val("e_fresh_ptr_p0_ready", p0_ready, 1);
        for (int i = 0; i < 4; i++) begin
            #1;
            check_val($sformatf("e_m2_p0_ready_%0d", i), p0_ready_m2, (i % 2 == 0) ? 1 : 0);
            check_val($sformatf("e_m2_p1_ready_%0d", i), p1_ready_m2, (i % 2 == 1) ? 1 : 0);
            tick();
            check_val($sformatf("e_m2_hint_%0d", i), out_hint_m2, 2'b10);
            check_val($sformatf("e_m2_hint_player_%0d", i), out_hint_player_m2, (i % 2 == 1) ? 1 : 0);
            check_val($sformatf("e_m2_done_%0d", i), done_m2, (i == 3) ? 1 : 0);
        end
        check_val("e_m2_result", result_m2, 2'b11);
        check_val("e_m2_tries0", tries0_m2, 2);
        check_val("e_m2_tries1", tries1_m2, 2);
        #1;
        check_val("e_m2_p0_ready_done", p0_ready_m2, 0);
        check_val("e_m2_p1_ready_done", p1_ready_m2, 0);
        p0_valid = 1'b0; p1_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
